noc_request_adapter: RTL and testbench

Node-side NoC adapter. Takes one merged memory request from the local core-side bridge and splits it into `FLITS_TO_SEND flits addressed to the memory node. It then collects the response flits from the memory node and reassembles them into one merged response for the core. It is the upstream peer of the memory-side flit buffer: its output flits are exactly what that buffer merges, and it consumes the flits that buffer splits back.

---
 rtl/noc_request_adapter_pkg.sv | 24 ++
 rtl/if_connect.sv | 25 ++
 rtl/flit_chunker.sv | 22 ++
 rtl/noc_request_adapter.sv | 131 +++++++++++++
 tb/tb_noc_request_adapter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_request_adapter_pkg.sv
// Shared widths, flit layout constants and the adapter state type for the
// node-side NoC request adapter.
package noc_request_adapter_pkg;

    localparam int NOC_NODE_WIDTH       = 2;
    localparam int USEFUL_DATA_WIDTH    = 32;
    localparam int MERGED_REQUEST_WIDTH = 72;

    // The request is cut into USEFUL-sized chunks; the last one carries the remainder.
    localparam int FLITS_TO_SEND   = (MERGED_REQUEST_WIDTH + USEFUL_DATA_WIDTH - 1) / USEFUL_DATA_WIDTH;
    localparam int MISSING         = MERGED_REQUEST_WIDTH - USEFUL_DATA_WIDTH * (FLITS_TO_SEND - 1);
    localparam int PADDING         = USEFUL_DATA_WIDTH - MISSING;
    localparam int FLIT_BODY_WIDTH = NOC_NODE_WIDTH + USEFUL_DATA_WIDTH;
    localparam int FLIT_WIDTH      = 3 + NOC_NODE_WIDTH + FLIT_BODY_WIDTH;
    localparam int INDEX_WIDTH     = (FLITS_TO_SEND > 1) ? $clog2(FLITS_TO_SEND) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RESP,
        DELIVER
    } state_t;

endpackage

// File: rtl/if_connect.sv
// Router port bundle between a node-side bridge and its NoC router.
interface if_connect;
    import noc_request_adapter_pkg::*;

    logic [NOC_NODE_WIDTH-1:0] this_id;
    logic [FLIT_WIDTH-1:0]     put_flit;
    logic                      en_put;
    logic [FLIT_WIDTH-1:0]     get_flit;
    logic                      en_get;
    logic                      en_get_non_full_VCs;
    logic                      en_put_non_full_VCs;
    logic [1:0]                put_non_full_VCs;

    modport bridge (
        input  this_id,
        input  get_flit,
        output put_flit,
        output en_put,
        output en_get,
        output en_get_non_full_VCs,
        output en_put_non_full_VCs,
        output put_non_full_VCs
    );

endinterface

// File: rtl/flit_chunker.sv
// Combinational chunk selector: picks the payload of flit 'index' out of a
// merged request, padding the short last chunk with ones.
module flit_chunker
    import noc_request_adapter_pkg::*;
(
    input  logic [MERGED_REQUEST_WIDTH-1:0] request,
    input  logic [INDEX_WIDTH-1:0]          index,
    output logic [USEFUL_DATA_WIDTH-1:0]    payload
);

    localparam logic [USEFUL_DATA_WIDTH-1:0] PAD_MASK = ~({USEFUL_DATA_WIDTH{1'b1}} >> PADDING);

    always_comb begin
        payload = PAD_MASK | USEFUL_DATA_WIDTH'(request[MERGED_REQUEST_WIDTH-1 -: MISSING]);
        for (int k = 0; k < FLITS_TO_SEND - 1; k++) begin
            if (index == INDEX_WIDTH'(k)) begin
                payload = request[USEFUL_DATA_WIDTH*k +: USEFUL_DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/noc_request_adapter.sv
// Splits a merged core request into flits for the memory node and reassembles
// the memory node's response flits into one merged response.
module noc_request_adapter
    import noc_request_adapter_pkg::*;
#(
    parameter int MEM_NODE_ID    = 0,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            res_n,
    if_connect.bridge                       noc,
    input  logic                            req_avail,
    output logic                            req_taken,
    input  logic [MERGED_REQUEST_WIDTH-1:0] merged_request_in,
    output logic                            resp_avail,
    input  logic                            resp_taken,
    output logic [MERGED_REQUEST_WIDTH-1:0] merged_response,
    output logic [DROP_CNT_WIDTH-1:0]       drop_count
);

    localparam logic [NOC_NODE_WIDTH-1:0] MEM_NODE   = NOC_NODE_WIDTH'(MEM_NODE_ID);
    localparam logic [INDEX_WIDTH-1:0]    LAST_INDEX = INDEX_WIDTH'(FLITS_TO_SEND - 1);

    state_t                          state;
    logic [INDEX_WIDTH-1:0]          index;
    logic [MERGED_REQUEST_WIDTH-1:0] request_q;
    logic [USEFUL_DATA_WIDTH-1:0]    chunk_payload;
    logic                            en_put_q;
    logic [FLIT_WIDTH-1:0]           put_flit_q;

    logic                            rx_valid;
    logic                            rx_accept;
    logic                            rx_drop;
    logic [NOC_NODE_WIDTH-1:0]       rx_sender;
    logic [USEFUL_DATA_WIDTH-1:0]    rx_payload;
    logic                            unused_rx_bits;

    flit_chunker u_chunker (
        .request (request_q),
        .index   (index),
        .payload (chunk_payload)
    );

    assign rx_valid       = noc.get_flit[FLIT_WIDTH-1];
    assign rx_sender      = noc.get_flit[FLIT_BODY_WIDTH-1 -: NOC_NODE_WIDTH];
    assign rx_payload     = noc.get_flit[USEFUL_DATA_WIDTH-1:0];
    assign unused_rx_bits = ^noc.get_flit[FLIT_WIDTH-2:FLIT_BODY_WIDTH];

    // Only the memory node may answer, and only while a response is expected.
    assign rx_accept = rx_valid && (state == WAIT_RESP) && (rx_sender == MEM_NODE);
    assign rx_drop   = rx_valid && !rx_accept;

    assign noc.put_flit            = put_flit_q;
    assign noc.en_put              = en_put_q;
    assign noc.en_get              = 1'b1;
    assign noc.en_get_non_full_VCs = 1'b1;
    assign noc.en_put_non_full_VCs = 1'b1;
    assign noc.put_non_full_VCs    = 2'b11;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state           <= IDLE;
            index           <= '0;
            request_q       <= '0;
            req_taken       <= 1'b0;
            resp_avail      <= 1'b0;
            merged_response <= '0;
            drop_count      <= '0;
            en_put_q        <= 1'b0;
            put_flit_q      <= '0;
        end else begin
            req_taken <= 1'b0;
            en_put_q  <= 1'b0;

            if (rx_drop && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req_avail) begin
                        request_q <= merged_request_in;
                        req_taken <= 1'b1;
                        index     <= '0;
                        state     <= SEND;
                    end
                end

                SEND: begin
                    put_flit_q <= {1'b1, 1'b0, MEM_NODE, 1'b0, noc.this_id, chunk_payload};
                    en_put_q   <= 1'b1;
                    if (index == LAST_INDEX) begin
                        index <= '0;
                        state <= WAIT_RESP;
                    end else begin
                        index <= index + 1'b1;
                    end
                end

                // The last slot keeps only the meaningful low bits; padding is discarded.
                WAIT_RESP: begin
                    if (rx_accept) begin
                        for (int k = 0; k < FLITS_TO_SEND - 1; k++) begin
                            if (index == INDEX_WIDTH'(k)) begin
                                merged_response[USEFUL_DATA_WIDTH*k +: USEFUL_DATA_WIDTH] <= rx_payload;
                            end
                        end
                        if (index == LAST_INDEX) begin
                            merged_response[MERGED_REQUEST_WIDTH-1 -: MISSING] <= rx_payload[MISSING-1:0];
                            index      <= '0;
                            resp_avail <= 1'b1;
                            state      <= DELIVER;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end

                DELIVER: begin
                    if (resp_taken) begin
                        resp_avail <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_request_adapter.sv
// Bench for noc_request_adapter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the adapter.
module tb_noc_request_adapter;
    import noc_request_adapter_pkg::*;

    localparam int F = FLITS_TO_SEND;

    logic        clk = 1'b0;
    logic        res_n;
    logic        req_avail;
    logic        req_taken;
    logic [71:0] merged_request_in;
    logic        resp_avail;
    logic        resp_taken;
    logic [71:0] merged_response;
    logic [7:0]  drop_count;

    if_connect noc_if ();

    noc_request_adapter #(
        .MEM_NODE_ID    (0),
        .DROP_CNT_WIDTH (8)
    ) dut (
        .clk               (clk),
        .res_n             (res_n),
        .noc               (noc_if),
        .req_avail         (req_avail),
        .req_taken         (req_taken),
        .merged_request_in (merged_request_in),
        .resp_avail        (resp_avail),
        .resp_taken        (resp_taken),
        .merged_response   (merged_response),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_failed   = 0;
    bit check_en   = 0;

    // Model: a request is "busy" from acceptance until its response is taken.
    bit          m_busy;
    int          m_sent;
    bit          m_hold;
    int          m_drop;
    logic [71:0] m_req;
    logic [31:0] m_words[$];
    bit          e_req_taken;
    bit          e_en_put;
    logic [38:0] e_flit;
    bit          e_resp_known;
    logic [71:0] e_resp;

    function automatic logic [31:0] chunk_of(input logic [71:0] req, input int k);
        if (k < F - 1) return 32'(req >> (32 * k));
        return (32'hFFFF_FFFF << MISSING) | 32'(req >> (32 * (F - 1)));
    endfunction

    function automatic logic [71:0] assemble(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        return 72'(w0) | (72'(w1) << 32) | (72'(w2 & 32'hFF) << 64);
    endfunction

    function automatic logic [38:0] tx_flit(input logic [31:0] payload);
        return {1'b1, 1'b0, 2'd0, 1'b0, 2'd1, payload};
    endfunction

    function automatic logic [38:0] rx_flit(input logic valid, input logic [1:0] sender, input logic [31:0] payload);
        return {valid, 1'b0, 2'd1, 1'b0, sender, payload};
    endfunction

    task automatic check_output(input string name, input logic [71:0] actual, input logic [71:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    task automatic model_step();
        logic        in_valid;
        logic [1:0]  in_sender;
        logic [31:0] in_pay;
        bit          accept;
        e_req_taken = 0;
        e_en_put    = 0;
        if (!res_n) begin
            m_busy = 0;
            m_sent = 0;
            m_hold = 0;
            m_drop = 0;
            m_words.delete();
            e_resp_known = 1;
            e_resp       = '0;
            return;
        end
        in_valid  = noc_if.get_flit[38];
        in_sender = noc_if.get_flit[33:32];
        in_pay    = noc_if.get_flit[31:0];
        accept    = in_valid && m_busy && (m_sent == F) && !m_hold && (in_sender == 2'd0);
        if (in_valid && !accept && m_drop < 255) m_drop++;
        if (!m_busy) begin
            if (req_avail) begin
                m_busy      = 1;
                m_sent      = 0;
                m_req       = merged_request_in;
                e_req_taken = 1;
            end
        end else if (m_sent < F) begin
            e_en_put = 1;
            e_flit   = tx_flit(chunk_of(m_req, m_sent));
            m_sent++;
        end else if (!m_hold) begin
            if (accept) begin
                m_words.push_back(in_pay);
                e_resp_known = 0;
                if (m_words.size() == F) begin
                    m_hold       = 1;
                    e_resp       = assemble(m_words[0], m_words[1], m_words[2]);
                    e_resp_known = 1;
                    m_words.delete();
                end
            end
        end else if (resp_taken) begin
            m_hold = 0;
            m_busy = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check_output("req_taken", req_taken, e_req_taken);
            check_output("en_put", noc_if.en_put, e_en_put);
            if (e_en_put) check_output("put_flit", noc_if.put_flit, e_flit);
            check_output("resp_avail", resp_avail, m_hold);
            if (e_resp_known) check_output("merged_response", merged_response, e_resp);
            check_output("drop_count", drop_count, m_drop);
        end
    end

    task automatic do_request(input logic [71:0] req);
        bit taken = 0;
        merged_request_in = req;
        req_avail = 1'b1;
        for (int i = 0; i < 30 && !taken; i++) begin
            tick();
            taken = e_req_taken;
        end
        req_avail = 1'b0;
        if (!taken) begin
            n_compared++;
            n_failed++;
            $display("[TB] FAIL req_timeout: got no req_taken, want pulse within 30 cycles");
        end
    endtask

    task automatic send_words(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
        noc_if.get_flit = rx_flit(1'b1, 2'd0, w0); tick();
        noc_if.get_flit = rx_flit(1'b1, 2'd0, w1); tick();
        noc_if.get_flit = rx_flit(1'b1, 2'd0, w2); tick();
        noc_if.get_flit = '0;
    endtask

    task automatic apply_stimulus();
        logic [95:0] tmp;
        logic [1:0]  sender;
        res_n = ($urandom_range(0, 249) != 0);
        if (!req_avail || e_req_taken) begin
            req_avail = ($urandom_range(0, 2) == 0);
            if (req_avail) begin
                tmp = {$urandom, $urandom, $urandom};
                merged_request_in = tmp[71:0];
            end
        end
        resp_taken = ($urandom_range(0, 3) == 0);
        sender = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        noc_if.get_flit = rx_flit(1'($urandom_range(0, 1)), sender, $urandom);
        tick();
    endtask

    initial begin
        logic [31:0] pin;
        res_n             = 1'b0;
        req_avail         = 1'b0;
        resp_taken        = 1'b0;
        merged_request_in = '0;
        noc_if.this_id    = 2'd1;
        noc_if.get_flit   = '0;

        pin = chunk_of(72'hAB_11223344_55667788, 0); check_output("model_chunk0", 72'(pin), 72'h55667788);
        pin = chunk_of(72'hAB_11223344_55667788, 1); check_output("model_chunk1", 72'(pin), 72'h11223344);
        pin = chunk_of(72'hAB_11223344_55667788, 2); check_output("model_chunk2", 72'(pin), 72'hFFFFFFAB);
        check_output("model_assemble", assemble(32'hDEADBEEF, 32'hCAFEF00D, 32'h000000C3), 72'hC3_CAFEF00D_DEADBEEF);

        tick();
        tick();
        check_en = 1;
        res_n = 1'b1;
        tick();
        check_output("en_get", noc_if.en_get, 1);
        check_output("en_get_nf", noc_if.en_get_non_full_VCs, 1);
        check_output("en_put_nf", noc_if.en_put_non_full_VCs, 1);
        check_output("put_nf_vcs", noc_if.put_non_full_VCs, 2'b11);

        // Directed request/response with a foreign flit in the middle.
        do_request(72'hAB_11223344_55667788);
        tick(); check_output("flit0", noc_if.put_flit, 39'h41_55667788);
        tick(); check_output("flit1", noc_if.put_flit, 39'h41_11223344);
        tick(); check_output("flit2", noc_if.put_flit, 39'h41_FFFFFFAB);
        noc_if.get_flit = rx_flit(1'b1, 2'd0, 32'hDEADBEEF); tick();
        noc_if.get_flit = rx_flit(1'b1, 2'd2, 32'h99999999); tick();
        check_output("drop_foreign", drop_count, 1);
        noc_if.get_flit = rx_flit(1'b1, 2'd0, 32'hCAFEF00D); tick();
        check_output("resp_early", resp_avail, 0);
        noc_if.get_flit = rx_flit(1'b1, 2'd0, 32'h000000C3); tick();
        noc_if.get_flit = '0;
        check_output("resp_avail_on", resp_avail, 1);
        check_output("resp_value", merged_response, 72'hC3_CAFEF00D_DEADBEEF);

        // Consumer stalls for 10 cycles while a new request waits.
        merged_request_in = 72'h5C_0BADC0DE_A5A5A5A5;
        req_avail = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_output("resp_held", merged_response, 72'hC3_CAFEF00D_DEADBEEF);
        resp_taken = 1'b1; tick(); resp_taken = 1'b0;
        check_output("no_take_yet", req_taken, 0);
        do_request(72'h5C_0BADC0DE_A5A5A5A5);
        check_output("take_after_resp", req_taken, 1);

        // Reset after two response words.
        tick(); tick(); tick();
        noc_if.get_flit = rx_flit(1'b1, 2'd0, 32'h11111111); tick();
        noc_if.get_flit = rx_flit(1'b1, 2'd0, 32'h22222222); tick();
        noc_if.get_flit = '0;
        res_n = 1'b0; tick(); res_n = 1'b1;
        check_output("rst_resp", merged_response, 0);
        check_output("rst_avail", resp_avail, 0);
        check_output("rst_drop", drop_count, 0);
        check_output("rst_en_put", noc_if.en_put, 0);
        tick();
        check_output("rst_no_flit", noc_if.en_put, 0);

        do_request(72'h77_00000000_FFFFFFFF);
        tick(); tick(); tick();
        send_words(32'h01234567, 32'h89ABCDEF, 32'hFFFFFF5A);
        check_output("resp_after_rst", merged_response, 72'h5A_89ABCDEF_01234567);
        resp_taken = 1'b1; tick(); resp_taken = 1'b0;

        // Drop counter saturation.
        noc_if.get_flit = rx_flit(1'b1, 2'd0, 32'h0); tick();
        check_output("drop_idle", drop_count, 1);
        for (int i = 0; i < 300; i++) begin
            noc_if.get_flit = rx_flit(1'b1, 2'd2, $urandom);
            tick();
        end
        noc_if.get_flit = '0;
        check_output("drop_sat", drop_count, 255);

        for (int c = 0; c < 4000; c++) apply_stimulus();

        res_n = 1'b1;
        req_avail = 1'b0;
        resp_taken = 1'b0;
        noc_if.get_flit = '0;
        tick(); tick();
        check_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
